// File: rtl/ram1_pkg.sv
// Shared definitions for the ram1 single-port memory: default geometry
// constants and the per-cycle access type decoded from cs/rw.
package ram1_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } op_t;

    // Classify the access presented in the current cycle.
    function automatic op_t decode_op(input logic cs, input logic rw);
        if (!cs) begin
            return IDLE;
        end
        return rw ? READ : WRITE;
    endfunction

endpackage

// File: rtl/ram1_array.sv
// Storage for ram1: 2**ADDR_W words of WORD_W bits, one write port,
// combinational read of the addressed word and synchronous clear of
// every word while rst is high. rst wins over a simultaneous write.
module ram1_array #(
    parameter int WORD_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH_L = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH_L];
    logic [WORD_W-1:0] mem_d [DEPTH_L];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH_L; gi++) begin : g_word
            // Next value of this word: load wdata only when addressed by a write.
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (we && (addr == ADDR_W'(gi))) begin
                    mem_d[gi] = wdata;
                end
            end

            // Word register with synchronous clear.
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ram1.sv
// ram1 top: single-port RAM with registered read data (1-cycle latency),
// no write-through, idle cycles hold the outputs. Optional per-word even
// parity is enabled by defining RAM1_PARITY_EN; without it perr stays 0.
module ram1
    import ram1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cs,
    input  logic              rw,
    output logic [DATA_W-1:0] o,
    output logic              perr
);

`ifdef RAM1_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    op_t               op;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic [DATA_W-1:0] o_q;
    logic [DATA_W-1:0] o_d;
    logic              perr_q;
    logic              perr_d;

    assign op = decode_op(cs, rw);

`ifdef RAM1_PARITY_EN
    // Parity bit sits above the data bits in each stored word.
    assign wr_word = {^d, d};
`else
    assign wr_word = d;
`endif

    ram1_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (op == WRITE),
        .addr  (addr),
        .wdata (wr_word),
        .rdata (rd_word)
    );

    // Output/flag next values: only a read updates them, everything else holds.
    always_comb begin
        o_d    = o_q;
        perr_d = perr_q;
        if (op == READ) begin
            o_d = rd_word[DATA_W-1:0];
`ifdef RAM1_PARITY_EN
            perr_d = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`else
            perr_d = 1'b0;
`endif
        end
    end

    // Output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q    <= '0;
            perr_q <= 1'b0;
        end else begin
            o_q    <= o_d;
            perr_q <= perr_d;
        end
    end

    assign o    = o_q;
    assign perr = perr_q;

endmodule

// File: tb/tb_ram1.sv
// Self-checking bench for ram1: directed scenarios followed by random
// traffic, all checked against a plain array model of the memory.
module tb_ram1;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int NW = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] d = '0;
    logic [AW-1:0] addr = '0;
    logic          cs = 1'b0;
    logic          rw = 1'b0;
    logic [DW-1:0] o;
    logic          perr;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    int ref_mem [NW];
    int ref_o    = 0;
    int ref_perr = 0;

    ram1 #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .addr (addr),
        .cs   (cs),
        .rw   (rw),
        .o    (o),
        .perr (perr)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs on the falling edge, apply the model at the
    // rising edge, then check the outputs 1 time unit after it.
    task automatic step(input logic r, input logic c, input logic w_rd,
                        input int a, input int dat, input string tag);
        @(negedge clk);
        rst  = r;
        cs   = c;
        rw   = w_rd;
        addr = AW'(a);
        d    = DW'(dat);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NW; i++) ref_mem[i] = 0;
            ref_o    = 0;
            ref_perr = 0;
        end else if (c && w_rd) begin
            ref_o    = ref_mem[a % NW];
            ref_perr = 0;
        end else if (c) begin
            ref_mem[a % NW] = dat % (2 ** DW);
        end
        #1;
        compared++;
        assert (o === DW'(ref_o)) else begin
            mismatched++;
            $error("FAIL %s o: got %0h want %0h", tag, o, ref_o);
        end
        compared++;
        assert (perr === ref_perr[0]) else begin
            mismatched++;
            $error("FAIL %s perr: got %0b want %0b", tag, perr, ref_perr[0]);
        end
        $display("%s rst=%0b cs=%0b rw=%0b addr=%0h d=%0h -> o=%0h perr=%0b",
                 tag, r, c, w_rd, a, dat, o, perr);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = 0;

        // Reset then read address 5.
        step(1, 0, 0, 0, 0, "reset");
        step(0, 1, 1, 5, 0, "rd_after_rst");

        // Extreme addresses and data.
        step(0, 1, 0, 15, 15, "wr_f_f");
        step(0, 1, 0, 0, 0, "wr_0_0");
        step(0, 1, 1, 15, 0, "rd_f");
        step(0, 1, 1, 0, 0, "rd_0");

        // Idle with rw=1 must hold o.
        step(0, 1, 0, 3, 10, "wr_3_a");
        step(0, 1, 1, 15, 0, "rd_f_again");
        step(0, 0, 1, 3, 5, "idle_rw1");
        step(0, 1, 1, 3, 0, "rd_3");

        // Write alone holds o; read straight after returns new data.
        step(0, 1, 0, 7, 6, "wr_7_6");
        step(0, 1, 1, 7, 0, "rd_7");

        // Fill with address pattern, read back in reverse.
        for (int i = 0; i < NW; i++) step(0, 1, 0, i, i, "fill");
        for (int i = NW - 1; i >= 0; i--) step(0, 1, 1, i, 0, "rev_rd");

        // Reset colliding with a read; memory cleared afterwards.
        step(0, 1, 0, 2, 9, "wr_2_9");
        step(1, 1, 1, 2, 0, "rst_with_rd");
        step(0, 1, 1, 2, 0, "rd_2_post_rst");
        step(0, 1, 1, 15, 0, "rd_f_post_rst");

`ifdef RAM1_PARITY_EN
        // Corrupt a stored parity bit and expect perr on the next read.
        step(0, 1, 0, 4, 3, "wr_4_3");
        @(negedge clk);
        dut.u_array.mem_q[4] = dut.u_array.mem_q[4] ^ 5'h10;
        cs = 1'b0;
        @(negedge clk);
        rst = 1'b0; cs = 1'b1; rw = 1'b1; addr = 4'd4;
        @(posedge clk);
        #1;
        compared++;
        assert (perr === 1'b1) else begin
            mismatched++;
            $error("FAIL par_flip perr: got %0b want 1", perr);
        end
        compared++;
        assert (o === 4'h3) else begin
            mismatched++;
            $error("FAIL par_flip o: got %0h want 3", o);
        end
        $display("par_flip addr=4 -> o=%0h perr=%0b", o, perr);
        ref_o = 3;
        ref_perr = 1;
        step(0, 1, 0, 4, 3, "wr_4_fix");
        step(0, 1, 1, 4, 0, "rd_4_fix");
`endif

        // Random traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, NW - 1)),
                 int'($urandom_range(0, 2 ** DW - 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
